// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift / rotate / parallel load, single-step or multi-step burst.
// Optional rotate support is compiled in when UNIV_SHIFT_ROTATE_EN is defined.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | accepts single steps (en) or a burst request (start)
// S_RUN  | burst in progress, one captured step per cycle, busy = 1
// S_DONE | burst finished, done = 1 for this cycle, inputs ignored
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [1:0]       op,
  input  logic             dir,
  input  logic             d,
  input  logic [WIDTH-1:0] par_in,
  input  logic             start,
  input  logic [CNTW-1:0]  amt,
  output logic [WIDTH-1:0] out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [1:0] OP_HOLD  = 2'b00;
  localparam logic [1:0] OP_SHIFT = 2'b01;
  localparam logic [1:0] OP_ROT   = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  state_t            r_state, w_state_nxt;
  logic [CNTW-1:0]   r_cnt, w_cnt_nxt;
  logic              r_brot, w_brot_nxt;
  logic              r_bdir, w_bdir_nxt;
  logic [WIDTH-1:0]  r_out, w_out_nxt;
  logic              r_ser, w_ser_nxt;
  logic              w_accept;
  logic              w_burst_op;

  // Returns {exiting bit, next value}; rotate feeds the exiting bit back instead of d.
  function automatic logic [WIDTH:0] f_step(input logic [WIDTH-1:0] v,
                                            input logic left,
                                            input logic rot,
                                            input logic fill_d);
    logic w_exit;
    logic w_fill;
    w_exit = left ? v[WIDTH-1] : v[0];
    w_fill = rot ? w_exit : fill_d;
    if (left) f_step = {w_exit, v[WIDTH-2:0], w_fill};
    else      f_step = {w_exit, w_fill, v[WIDTH-1:1]};
  endfunction

`ifdef UNIV_SHIFT_ROTATE_EN
  assign w_burst_op = (op == OP_SHIFT) || (op == OP_ROT);
`else
  assign w_burst_op = (op == OP_SHIFT);
`endif

  assign w_accept = (r_state == S_IDLE) && start && w_burst_op;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_brot_nxt  = r_brot;
    w_bdir_nxt  = r_bdir;
    w_out_nxt   = r_out;
    w_ser_nxt   = r_ser;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
`ifdef UNIV_SHIFT_ROTATE_EN
          w_brot_nxt = (op == OP_ROT);
`else
          w_brot_nxt = 1'b0;
`endif
          w_bdir_nxt = dir;
          if (amt == '0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_cnt_nxt   = amt;
            w_state_nxt = S_RUN;
          end
        end else if (en) begin
          case (op)
            OP_SHIFT: {w_ser_nxt, w_out_nxt} = f_step(r_out, dir, 1'b0, d);
`ifdef UNIV_SHIFT_ROTATE_EN
            OP_ROT:   {w_ser_nxt, w_out_nxt} = f_step(r_out, dir, 1'b1, d);
`endif
            OP_LOAD:  w_out_nxt = par_in;
            default:  ;
          endcase
        end
      end
      S_RUN: begin
        {w_ser_nxt, w_out_nxt} = f_step(r_out, r_bdir, r_brot, d);
        w_cnt_nxt = r_cnt - CNTW'(1);
        if (r_cnt == CNTW'(1)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_brot  <= 1'b0;
      r_bdir  <= 1'b0;
      r_out   <= '0;
      r_ser   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_brot  <= w_brot_nxt;
      r_bdir  <= w_bdir_nxt;
      r_out   <= w_out_nxt;
      r_ser   <= w_ser_nxt;
    end
  end

  assign out     = r_out;
  assign ser_out = r_ser;
  assign busy    = (r_state == S_RUN);
  assign done    = (r_state == S_DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed scenarios plus random stimulus
// compared every cycle against an arithmetic reference model.
module tb_univ_shift_reg;
  localparam int W  = 8;
  localparam int CW = 4;
`ifdef UNIV_SHIFT_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic          en;
  logic [1:0]    op;
  logic          dir;
  logic          d;
  logic [W-1:0]  par_in;
  logic          start;
  logic [CW-1:0] amt;
  logic [W-1:0]  out;
  logic          ser_out;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(W), .CNTW(CW)) dut (
    .clk(clk), .rstn(rstn), .en(en), .op(op), .dir(dir), .d(d),
    .par_in(par_in), .start(start), .amt(amt),
    .out(out), .ser_out(ser_out), .busy(busy), .done(done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: remaining burst steps as a plain integer
  logic [W-1:0] m_out;
  bit           m_ser;
  int           m_left;
  bit           m_done;
  bit           m_brot;
  bit           m_bdir;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic m_reset();
    m_out = '0; m_ser = 0; m_left = 0; m_done = 0; m_brot = 0; m_bdir = 0;
  endtask

  task automatic m_step(input bit rot, input bit left, input bit fill_d);
    bit ex;
    bit fill;
    if (left) begin
      ex    = ((m_out >> (W-1)) & 1) != 0;
      fill  = rot ? ex : fill_d;
      m_out = (m_out << 1) | W'(fill);
    end else begin
      ex    = (m_out & 1) != 0;
      fill  = rot ? ex : fill_d;
      m_out = (m_out >> 1) | (fill ? (W'(1) << (W-1)) : W'(0));
    end
    m_ser = ex;
  endtask

  task automatic m_edge();
    if (!rstn) begin
      m_reset();
    end else if (m_done) begin
      m_done = 0;
    end else if (m_left > 0) begin
      m_step(m_brot, m_bdir, d);
      m_left--;
      if (m_left == 0) m_done = 1;
    end else if (start && (op == 2'b01 || (ROT && op == 2'b10))) begin
      m_brot = (op == 2'b10);
      m_bdir = dir;
      if (amt == 0) m_done = 1;
      else m_left = int'(amt);
    end else if (en) begin
      if (op == 2'b01) m_step(1'b0, dir, d);
      else if (op == 2'b10 && ROT) m_step(1'b1, dir, d);
      else if (op == 2'b11) m_out = par_in;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
    @(negedge clk);
    check("out", 32'(out), 32'(m_out));
    check("ser_out", 32'(ser_out), 32'(m_ser));
    check("busy", 32'(busy), 32'(m_left > 0));
    check("done", 32'(done), 32'(m_done));
  endtask

  task automatic drive(input bit i_en, input logic [1:0] i_op, input bit i_dir, input bit i_d,
                       input logic [W-1:0] i_par, input bit i_start, input logic [CW-1:0] i_amt);
    en = i_en; op = i_op; dir = i_dir; d = i_d; par_in = i_par; start = i_start; amt = i_amt;
  endtask

  int busy_cnt;
  int done_cnt;

  initial begin
    rstn = 1'b0;
    drive(0, 2'b00, 0, 0, '0, 0, '0);
    m_reset();
    tick();
    tick();
    check("reset_out", 32'(out), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    rstn = 1'b1;
    tick();

    // load A5, single right shift with d=1
    drive(1, 2'b11, 0, 0, 8'hA5, 0, '0); tick();
    drive(1, 2'b01, 0, 1, 8'h00, 0, '0); tick();
    check("single_shift_out", 32'(out), 32'hD2);
    check("single_shift_ser", 32'(ser_out), 32'h1);

    // left shift burst of 3 with en/op noise during the burst
    drive(1, 2'b11, 0, 0, 8'h81, 0, '0); tick();
    drive(0, 2'b01, 1, 0, 8'h00, 1, 4'd3);
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (i == 3) check("lburst_out", 32'(out), 32'h08);
      drive(i[0], 2'b11, 0, 0, 8'hFF, 0, 4'd7);
    end
    check("lburst_busy_cycles", 32'(busy_cnt), 32'd3);
    check("lburst_done_pulses", 32'(done_cnt), 32'd1);

    // rotate right burst of 8
    drive(1, 2'b11, 0, 0, 8'h01, 0, '0); tick();
    drive(0, 2'b10, 0, 1, 8'h00, 1, 4'd8); tick();
    drive(0, 2'b00, 0, 1, 8'h00, 0, '0); tick();
    if (ROT) check("rot_step1", 32'(out), 32'h80);
    for (int i = 0; i < 8; i++) tick();
    check("rot_final", 32'(out), 32'h01);

    // zero-amount burst, then a start held high through done
    drive(0, 2'b01, 0, 0, 8'h00, 1, 4'd0); tick();
    check("zero_done", 32'(done), 32'h1);
    check("zero_busy", 32'(busy), 32'h0);
    drive(0, 2'b01, 1, 1, 8'h00, 1, 4'd2); tick();
    check("b2b_ignored_in_done", 32'(busy), 32'h0);
    tick();
    check("b2b_accepted", 32'(busy), 32'h1);
    drive(0, 2'b00, 0, 0, 8'h00, 0, '0);
    for (int i = 0; i < 3; i++) tick();

    // asynchronous reset after step 4 of a 10-step burst
    drive(0, 2'b01, 0, 1, 8'h00, 1, 4'd10); tick();
    drive(0, 2'b00, 0, 1, 8'h00, 0, '0);
    for (int i = 0; i < 4; i++) tick();
    rstn = 1'b0;
    #1;
    check("rst_mid_out", 32'(out), 32'h0);
    check("rst_mid_busy", 32'(busy), 32'h0);
    check("rst_mid_done", 32'(done), 32'h0);
    m_reset();
    tick();
    rstn = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) done_cnt++;
    end
    check("rst_mid_no_done", 32'(done_cnt), 32'd0);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), W'($urandom), ($urandom_range(0, 5) == 0),
            CW'($urandom_range(0, 15)));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
